ehl_timer_apb_mc: RTL and testbench



---
 rtl/ehl_timer_mc_pkg.sv | 26 ++
 rtl/ehl_timer_mc_channel.sv | 119 +++++++++++
 rtl/ehl_timer_apb_mc.sv | 131 +++++++++++++
 tb/tb_ehl_timer_apb_mc.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ehl_timer_mc_pkg.sv
// Shared constants for the multi-channel APB timer: register offsets, CTRL bit
// positions and the channel-count ceiling.
package ehl_timer_mc_pkg;

  localparam int unsigned MAX_NCH = 8;

  // Offsets inside a 16-byte channel window
  localparam logic [3:0] OffCtrl  = 4'h0;
  localparam logic [3:0] OffLoad  = 4'h4;
  localparam logic [3:0] OffValue = 4'h8;
  localparam logic [3:0] OffCmp   = 4'hC;

  // Global registers; everything from AddrFirstInvalid upward is unmapped
  localparam logic [7:0] AddrIrqStat      = 8'h80;
  localparam logic [7:0] AddrIrqMask      = 8'h84;
  localparam logic [7:0] AddrFirstInvalid = 8'h90;

  // CTRL bit positions
  localparam int unsigned CtrlEn       = 0;
  localparam int unsigned CtrlOneshot  = 1;
  localparam int unsigned CtrlPwmEn    = 2;
  localparam int unsigned CtrlPol      = 3;
  localparam int unsigned CtrlPrescLsb = 8;
  localparam int unsigned CtrlPrescMsb = 15;

endpackage

// File: rtl/ehl_timer_mc_channel.sv
// One timer channel: CTRL/LOAD/CMP registers, 8-bit prescaler, down-counter
// with periodic or one-shot reload, single-cycle zero/compare event pulses and
// the PWM compare output.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   ctrl_we_i/load_we_i/
//   cmp_we_i               register write strobes (already decoded)
//   wdata_i                write data, zero-extended to 32 bits
//   ctrl_o/load_o/value_o/
//   cmp_o                  register contents for the read mux
//   zero_evt_o, cmp_evt_o  one-cycle event pulses, aligned with the tick
//   pwm_o                  PWM / compare output
module ehl_timer_mc_channel
  import ehl_timer_mc_pkg::*;
#(
  parameter int unsigned TimerWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ctrl_we_i,
  input  logic                  load_we_i,
  input  logic                  cmp_we_i,
  input  logic [31:0]           wdata_i,
  output logic [15:0]           ctrl_o,
  output logic [TimerWidth-1:0] load_o,
  output logic [TimerWidth-1:0] value_o,
  output logic [TimerWidth-1:0] cmp_o,
  output logic                  zero_evt_o,
  output logic                  cmp_evt_o,
  output logic                  pwm_o
);

  logic                  en_q, en_d;
  logic                  oneshot_q, pwm_en_q, pol_q;
  logic [7:0]            presc_q;
  logic [7:0]            pcnt_q, pcnt_d;
  logic [TimerWidth-1:0] value_q, value_d;
  logic [TimerWidth-1:0] load_q, cmp_q;
  logic                  tick, at_zero, hw_stop, start;

  // Prescaler counts down from PRESC; a tick fires when it reaches zero.
  assign tick    = en_q && (pcnt_q == 8'd0);
  assign at_zero = (value_q == '0);
  assign hw_stop = tick && at_zero && oneshot_q;
  // A software EN=1 restarts the counter if it was idle or is being stopped
  // by the one-shot on this very edge.
  assign start   = ctrl_we_i && wdata_i[CtrlEn] && (!en_q || hw_stop);

  always_comb begin
    en_d    = en_q;
    value_d = value_q;
    pcnt_d  = pcnt_q;
    if (ctrl_we_i) begin
      en_d = wdata_i[CtrlEn];
    end else if (hw_stop) begin
      en_d = 1'b0;
    end
    if (start) begin
      value_d = load_q;
      pcnt_d  = wdata_i[CtrlPrescMsb:CtrlPrescLsb];
    end else if (tick) begin
      // Reloading from presc_q here makes a PRESC change apply at the next wrap
      pcnt_d = presc_q;
      if (!at_zero) begin
        value_d = value_q - TimerWidth'(1);
      end else if (!oneshot_q) begin
        value_d = load_q;
      end
    end else if (en_q) begin
      pcnt_d = pcnt_q - 8'd1;
    end
    if (!en_d) begin
      pcnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      pwm_en_q  <= 1'b0;
      pol_q     <= 1'b0;
      presc_q   <= 8'd0;
      pcnt_q    <= 8'd0;
      value_q   <= '0;
      load_q    <= '0;
      cmp_q     <= '0;
    end else begin
      en_q    <= en_d;
      pcnt_q  <= pcnt_d;
      value_q <= value_d;
      if (ctrl_we_i) begin
        oneshot_q <= wdata_i[CtrlOneshot];
        pwm_en_q  <= wdata_i[CtrlPwmEn];
        pol_q     <= wdata_i[CtrlPol];
        presc_q   <= wdata_i[CtrlPrescMsb:CtrlPrescLsb];
      end
      if (load_we_i) begin
        load_q <= wdata_i[TimerWidth-1:0];
      end
      if (cmp_we_i) begin
        cmp_q <= wdata_i[TimerWidth-1:0];
      end
    end
  end

  assign ctrl_o     = {presc_q, 4'b0000, pol_q, pwm_en_q, oneshot_q, en_q};
  assign load_o     = load_q;
  assign value_o    = value_q;
  assign cmp_o      = cmp_q;
  assign zero_evt_o = tick && at_zero;
  assign cmp_evt_o  = tick && (value_q == cmp_q);
  assign pwm_o      = pwm_en_q ? ((value_q < cmp_q) ^ pol_q) : pol_q;

  // Not every write-data bit lands in a register
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

endmodule

// File: rtl/ehl_timer_apb_mc.sv
// Multi-channel APB timer. Zero-wait-state APB slave with error response for
// unmapped or misaligned addresses, NCH timer channels, and a combined,
// maskable interrupt built from IRQ_STAT & IRQ_MASK.
// Ports:
//   pclk, presetn           bus/timer clock, synchronous active-low reset
//   paddr, psel, penable,
//   pwrite, pwdata          APB request
//   prdata, pready, pslverr APB response (prdata is zero outside valid reads)
//   irq                     combined interrupt
//   pwm_out                 per-channel PWM / compare outputs
module ehl_timer_apb_mc
  import ehl_timer_mc_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned TIMER_WIDTH = 16,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [7:0]            paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  irq,
  output logic [NCH-1:0]        pwm_out
);

  localparam int unsigned NFlag = 2 * NCH;

  logic        access, wr, rd, bad, is_global;
  logic [2:0]  ch_idx;
  logic [31:0] wd32;

  assign ch_idx    = paddr[6:4];
  assign is_global = paddr[7];
  assign wd32      = 32'(pwdata);
  assign access    = psel && penable;
  assign bad       = (paddr[1:0] != 2'b00) || (paddr >= AddrFirstInvalid) ||
                     (!is_global && (32'(ch_idx) >= NCH));
  assign wr        = access && pwrite && !bad;
  assign rd        = access && !pwrite && !bad;
  assign pslverr   = access && bad;
  assign pready    = 1'b1;

  logic [NCH-1:0]         zero_evt, cmp_evt;
  logic [15:0]            ch_ctrl  [NCH];
  logic [TIMER_WIDTH-1:0] ch_load  [NCH];
  logic [TIMER_WIDTH-1:0] ch_value [NCH];
  logic [TIMER_WIDTH-1:0] ch_cmp   [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic sel;
    assign sel = wr && !is_global && (ch_idx == 3'(c));

    ehl_timer_mc_channel #(
      .TimerWidth (TIMER_WIDTH)
    ) u_channel (
      .clk_i      (pclk),
      .rst_ni     (presetn),
      .ctrl_we_i  (sel && (paddr[3:0] == OffCtrl)),
      .load_we_i  (sel && (paddr[3:0] == OffLoad)),
      .cmp_we_i   (sel && (paddr[3:0] == OffCmp)),
      .wdata_i    (wd32),
      .ctrl_o     (ch_ctrl[c]),
      .load_o     (ch_load[c]),
      .value_o    (ch_value[c]),
      .cmp_o      (ch_cmp[c]),
      .zero_evt_o (zero_evt[c]),
      .cmp_evt_o  (cmp_evt[c]),
      .pwm_o      (pwm_out[c])
    );
  end

  logic [NFlag-1:0] stat_q, stat_d, mask_q, hw_set;

  always_comb begin
    hw_set = '0;
    for (int c = 0; c < NCH; c++) begin
      hw_set[2*c]   = zero_evt[c];
      hw_set[2*c+1] = cmp_evt[c];
    end
    stat_d = stat_q;
    if (wr && (paddr == AddrIrqStat)) begin
      stat_d = stat_q & ~wd32[NFlag-1:0];
    end
    // Hardware set is applied last so it wins over a same-cycle clear
    stat_d = stat_d | hw_set;
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      stat_q <= '0;
      mask_q <= '0;
    end else begin
      stat_q <= stat_d;
      if (wr && (paddr == AddrIrqMask)) begin
        mask_q <= wd32[NFlag-1:0];
      end
    end
  end

  assign irq = |(stat_q & mask_q);

  always_comb begin
    prdata = '0;
    if (rd) begin
      if (paddr == AddrIrqStat) begin
        prdata = DATA_WIDTH'(stat_q);
      end else if (paddr == AddrIrqMask) begin
        prdata = DATA_WIDTH'(mask_q);
      end else if (!is_global) begin
        for (int c = 0; c < NCH; c++) begin
          if (ch_idx == 3'(c)) begin
            case (paddr[3:0])
              OffCtrl:  prdata = DATA_WIDTH'(ch_ctrl[c]);
              OffLoad:  prdata = DATA_WIDTH'(ch_load[c]);
              OffValue: prdata = DATA_WIDTH'(ch_value[c]);
              OffCmp:   prdata = DATA_WIDTH'(ch_cmp[c]);
              default:  prdata = '0;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ehl_timer_apb_mc.sv
module tb_ehl_timer_apb_mc;

  localparam int unsigned NCH = 2;
  localparam int unsigned TW  = 16;
  localparam int unsigned DW  = 32;

  logic           pclk = 1'b0;
  logic           presetn, psel, penable, pwrite;
  logic [7:0]     paddr;
  logic [DW-1:0]  pwdata, prdata;
  logic           pready, pslverr, irq;
  logic [NCH-1:0] pwm_out;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  ehl_timer_apb_mc #(
    .NCH         (NCH),
    .TIMER_WIDTH (TW),
    .DATA_WIDTH  (DW)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .irq     (irq),
    .pwm_out (pwm_out)
  );

  typedef struct {
    logic        is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Setup after one edge, access after the next, commit on the third.
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1 begin d = prdata; err = pslverr; end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic e;
    apb_write(a, d, e);
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(a, d, e);
    check(name, d, exp);
  endtask

  task automatic add(input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input logic err, input string name);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.exp = exp; v.exp_err = err; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          cnt;

    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    do_reset();
    check("rst_irq", irq, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_pslverr", pslverr, 0);
    check("rst_prdata", prdata, 0);
    check("pready", pready, 1);

    // Register map, reset values, masking and error responses
    add(0, 8'h00, 0, 32'h0, 0, "rst_ctrl0");
    add(0, 8'h04, 0, 32'h0, 0, "rst_load0");
    add(0, 8'h08, 0, 32'h0, 0, "rst_value0");
    add(0, 8'h0C, 0, 32'h0, 0, "rst_cmp0");
    add(0, 8'h10, 0, 32'h0, 0, "rst_ctrl1");
    add(0, 8'h1C, 0, 32'h0, 0, "rst_cmp1");
    add(0, 8'h80, 0, 32'h0, 0, "rst_stat");
    add(0, 8'h84, 0, 32'h0, 0, "rst_mask");
    add(1, 8'h04, 32'h1234, 0, 0, "wr_load0");
    add(0, 8'h04, 0, 32'h1234, 0, "rd_load0");
    add(1, 8'h0C, 32'hFFFF_ABCD, 0, 0, "wr_cmp0");
    add(0, 8'h0C, 0, 32'h0000_ABCD, 0, "rd_cmp0_trunc");
    add(1, 8'h00, 32'h0000_ABFC, 0, 0, "wr_ctrl0");
    add(0, 8'h00, 0, 32'h0000_AB0C, 0, "rd_ctrl0_unused0");
    add(1, 8'h08, 32'h55, 0, 0, "wr_value_ro");
    add(0, 8'h08, 0, 32'h0, 0, "rd_value_ro");
    add(1, 8'h94, 32'h1, 0, 1, "wr_94_err");
    add(0, 8'h94, 0, 32'h0, 1, "rd_94_err");
    add(0, 8'h14, 0, 32'h0, 0, "rd_load1_untouched");
    add(1, 8'h20, 32'h7, 0, 1, "wr_ch2_err");
    add(0, 8'h20, 0, 32'h0, 1, "rd_ch2_err");
    add(1, 8'h02, 32'hFF, 0, 1, "wr_misalign_err");
    add(0, 8'h00, 0, 32'h0000_AB0C, 0, "rd_ctrl0_unchanged");
    add(0, 8'h02, 0, 32'h0, 1, "rd_misalign_err");
    add(1, 8'h84, 32'hFFFF, 0, 0, "wr_mask");
    add(0, 8'h84, 0, 32'hF, 0, "rd_mask_width");
    add(0, 8'h88, 0, 32'h0, 0, "rd_88_hole");

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) begin
        apb_write(vecs[i].addr, vecs[i].data, e);
      end else begin
        apb_read(vecs[i].addr, d, e);
        check(vecs[i].name, d, vecs[i].exp);
      end
      check({vecs[i].name, "_err"}, e, vecs[i].exp_err);
    end
    do_reset();

    // Ch0 periodic, LOAD=3 PRESC=0: zero event 4 cycles after enable
    wr(8'h04, 3);
    wr(8'h84, 1);
    wr(8'h00, 1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge pclk); #1;
      check($sformatf("per_irq_k%0d", k), irq, (k == 4) ? 1 : 0);
    end
    wr(8'h80, 1);                 // commits 3 cycles after the event, clear of the next
    check("w1c_drop", irq, 0);
    @(posedge pclk); #1;
    check("per_irq_again", irq, 1);
    @(posedge pclk); #1;
    wr(8'h80, 1);                 // commits on the same edge as the next zero event
    check("w1c_vs_set", irq, 1);
    rd_check("stat_after_race", 8'h80, 32'h3);

    // Reset while counting
    presetn = 1'b0;
    @(posedge pclk); #1 presetn = 1'b1;
    check("midreset_irq", irq, 0);
    rd_check("midreset_ctrl0", 8'h00, 0);
    rd_check("midreset_value0", 8'h08, 0);
    rd_check("midreset_stat", 8'h80, 0);

    // Ch1 one-shot, LOAD=5 PRESC=1: single zero event 12 cycles after enable
    wr(8'h14, 5);
    wr(8'h84, 4);
    wr(8'h10, 32'h0103);
    for (int k = 1; k <= 14; k++) begin
      @(posedge pclk); #1;
      check($sformatf("os_irq_k%0d", k), irq, (k >= 12) ? 1 : 0);
    end
    rd_check("os_ctrl_en_cleared", 8'h10, 32'h0102);
    rd_check("os_value_hold", 8'h18, 0);
    wr(8'h80, 4);
    repeat (20) @(posedge pclk);
    #1 check("os_single_event", irq, 0);

    // One-shot stop and software EN=1 on the same edge: counter restarts
    wr(8'h14, 2);
    wr(8'h10, 32'h3);             // value 2 -> 1 -> 0, stop due on the 3rd edge
    wr(8'h10, 32'h3);             // commits on that 3rd edge
    rd_check("sw_wins_en", 8'h10, 32'h3);
    rd_check("sw_wins_value_end", 8'h18, 0);
    rd_check("sw_wins_stopped", 8'h10, 32'h2);

    // Ch0 PWM, LOAD=9 CMP=3: high 3 of every 10 ticks, inverted with POL
    wr(8'h0C, 3);
    wr(8'h04, 9);
    wr(8'h00, 32'h5);
    check("pwm_first", pwm_out[0], 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin
        @(posedge pclk); #1;
      end
      cnt += int'(pwm_out[0]);
    end
    check("pwm_hi_count", cnt, 6);
    wr(8'h00, 32'hD);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge pclk); #1;
      cnt += int'(pwm_out[0]);
    end
    check("pwm_pol_hi_count", cnt, 14);
    check("pwm_ch1_idle", pwm_out[1], 0);
    wr(8'h00, 32'h9);
    check("pwm_disabled_pol", pwm_out[0], 1);
    wr(8'h00, 32'h0);
    check("pwm_off", pwm_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
